// File: rtl/morra_pkg.sv
// Shared encodings and FSM state type for the MorraCinese match sequencer.
package morra_pkg;

   localparam int unsigned MOVE_W = 2;

   typedef logic [MOVE_W-1:0] move_t;

   // Player moves
   localparam move_t MOVE_NONE    = 2'b00;
   localparam move_t MOVE_SASSO   = 2'b01;
   localparam move_t MOVE_CARTA   = 2'b10;
   localparam move_t MOVE_FORBICE = 2'b11;

   // Per-manche result from the core
   localparam move_t MANCHE_INVALID = 2'b00;
   localparam move_t MANCHE_P1      = 2'b01;
   localparam move_t MANCHE_P2      = 2'b10;
   localparam move_t MANCHE_DRAW    = 2'b11;

   // Match status from the core
   localparam move_t PARTITA_ONGOING = 2'b00;
   localparam move_t PARTITA_P1      = 2'b01;
   localparam move_t PARTITA_P2      = 2'b10;
   localparam move_t PARTITA_DRAW    = 2'b11;

   typedef struct packed {
      move_t primo;
      move_t secondo;
   } move_pair_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      COLLECT,
      PLAY,
      RESULT,
      DONE
   } state_t;

   // An invalid manche is reported but does not advance the manche count.
   function automatic logic manche_counts(input move_t m);
      return m != MANCHE_INVALID;
   endfunction

endpackage

// File: rtl/morra_move_slot.sv
// One player's move slot: valid/ready capture register with full flag and clear.
module morra_move_slot
   import morra_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  valid,
   input  move_t move,
   input  logic  collect_nxt,
   input  logic  clr,
   output logic  ready,
   output logic  full,
   output logic  hs_c,
   output move_t data_c
);

   move_t data;
   logic  full_c;

   assign hs_c   = valid && ready;
   assign full_c = !clr && (full || hs_c);
   assign data_c = clr ? MOVE_NONE : (hs_c ? move : data);

   // READY is registered against the slot's next occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready <= 1'b0;
         full  <= 1'b0;
         data  <= MOVE_NONE;
      end else begin
         ready <= collect_nxt && !full_c;
         full  <= full_c;
         data  <= data_c;
      end
   end

endmodule

// File: rtl/morra_match_sequencer.sv
// Drives the MorraCinese core through a full match: collects move pairs,
// plays them for one cycle, reports manche results and latches the winner.
module morra_match_sequencer
   import morra_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             START,
   input  logic             P1_VALID,
   input  logic [1:0]       P1_MOVE,
   output logic             P1_READY,
   input  logic             P2_VALID,
   input  logic [1:0]       P2_MOVE,
   output logic             P2_READY,
   output logic [1:0]       CORE_PRIMO,
   output logic [1:0]       CORE_SECONDO,
   output logic             CORE_INIZIO,
   input  logic [1:0]       CORE_MANCHE,
   input  logic [1:0]       CORE_PARTITA,
   output logic             RES_VALID,
   output logic [1:0]       RES_MANCHE,
   output logic             BUSY,
   output logic             GAME_OVER,
   output logic [1:0]       WINNER,
   output logic [CNT_W-1:0] N_MANCHE,
   output logic             TIMEOUT
);

   localparam int unsigned TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t            state;
   state_t            state_nxt;
   logic              p1_hs_c;
   logic              p2_hs_c;
   logic              p1_full;
   logic              p2_full;
   move_pair_t        pair_c;
   logic              both_c;
   logic              one_full;
   logic              expire_c;
   logic              slot_clr_c;
   logic              collect_nxt;
   logic [TCNT_W-1:0] tcnt;
   logic [TCNT_W-1:0] tcnt_nxt;

   morra_move_slot u_slot_p1 (
      .clk         (clk),
      .rst         (RST),
      .valid       (P1_VALID),
      .move        (P1_MOVE),
      .collect_nxt (collect_nxt),
      .clr         (slot_clr_c),
      .ready       (P1_READY),
      .full        (p1_full),
      .hs_c        (p1_hs_c),
      .data_c      (pair_c.primo)
   );

   morra_move_slot u_slot_p2 (
      .clk         (clk),
      .rst         (RST),
      .valid       (P2_VALID),
      .move        (P2_MOVE),
      .collect_nxt (collect_nxt),
      .clr         (slot_clr_c),
      .ready       (P2_READY),
      .full        (p2_full),
      .hs_c        (p2_hs_c),
      .data_c      (pair_c.secondo)
   );

   // A pair is complete this cycle if each slot is full or is being filled now.
   assign both_c      = (p1_full || p1_hs_c) && (p2_full || p2_hs_c);
   assign one_full    = p1_full ^ p2_full;
   assign collect_nxt = (state_nxt == COLLECT);
   assign slot_clr_c  = (state == CLEAR) || (state == PLAY) || expire_c;

   // Half-pair timeout; a late arrival in the expiry cycle suppresses it.
   always_comb begin
      tcnt_nxt = '0;
      expire_c = 1'b0;
      if ((state == COLLECT) && one_full && !both_c) begin
         if (tcnt == TCNT_LAST) begin
            expire_c = 1'b1;
         end else begin
            tcnt_nxt = tcnt + TCNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         tcnt  <= '0;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (START) state_nxt = CLEAR;
         CLEAR:   state_nxt = COLLECT;
         COLLECT: if (both_c) state_nxt = PLAY;
         PLAY:    state_nxt = RESULT;
         RESULT:  state_nxt = (CORE_PARTITA != PARTITA_ONGOING) ? DONE : COLLECT;
         DONE:    if (START) state_nxt = CLEAR;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they align with it.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         CORE_PRIMO   <= MOVE_NONE;
         CORE_SECONDO <= MOVE_NONE;
         CORE_INIZIO  <= 1'b0;
         RES_VALID    <= 1'b0;
         RES_MANCHE   <= MANCHE_INVALID;
         BUSY         <= 1'b0;
         GAME_OVER    <= 1'b0;
         WINNER       <= PARTITA_ONGOING;
         N_MANCHE     <= '0;
         TIMEOUT      <= 1'b0;
      end else begin
         CORE_INIZIO  <= (state_nxt == CLEAR);
         CORE_PRIMO   <= (state_nxt == PLAY) ? pair_c.primo   : MOVE_NONE;
         CORE_SECONDO <= (state_nxt == PLAY) ? pair_c.secondo : MOVE_NONE;
         BUSY         <= (state_nxt == CLEAR) || (state_nxt == COLLECT) ||
                         (state_nxt == PLAY)  || (state_nxt == RESULT);
         GAME_OVER    <= (state_nxt == DONE);
         TIMEOUT      <= expire_c;
         RES_VALID    <= (state == RESULT);
         if (state_nxt == CLEAR) begin
            RES_MANCHE <= MANCHE_INVALID;
            WINNER     <= PARTITA_ONGOING;
            N_MANCHE   <= '0;
         end else if (state == RESULT) begin
            RES_MANCHE <= CORE_MANCHE;
            if (manche_counts(CORE_MANCHE) && (N_MANCHE != CNT_MAX)) begin
               N_MANCHE <= N_MANCHE + CNT_W'(1);
            end
            if (CORE_PARTITA != PARTITA_ONGOING) begin
               WINNER <= CORE_PARTITA;
            end
         end
      end
   end

endmodule
